// File: rtl/ahb_ram_arbiter.sv
// ahb_ram_arbiter: CPU port (S0) and DMA port (S1) sharing one AHB SRAM.
// A losing request is buffered one-deep per port and replayed as NONSEQ.

module ahb_ram_arbiter #(
    parameter int ARB_MODE = 0
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL_S0,
    input  logic [31:0] HADDR_S0,
    input  logic [1:0]  HTRANS_S0,
    input  logic [2:0]  HSIZE_S0,
    input  logic        HWRITE_S0,
    input  logic [31:0] HWDATA_S0,
    input  logic        HREADY_S0,
    output logic        HREADYOUT_S0,
    output logic        HRESP_S0,
    output logic [31:0] HRDATA_S0,
    input  logic        HSEL_S1,
    input  logic [31:0] HADDR_S1,
    input  logic [1:0]  HTRANS_S1,
    input  logic [2:0]  HSIZE_S1,
    input  logic        HWRITE_S1,
    input  logic [31:0] HWDATA_S1,
    input  logic        HREADY_S1,
    output logic        HREADYOUT_S1,
    output logic        HRESP_S1,
    output logic [31:0] HRDATA_S1,
    output logic        HSEL_M,
    output logic [31:0] HADDR_M,
    output logic [1:0]  HTRANS_M,
    output logic [2:0]  HSIZE_M,
    output logic        HWRITE_M,
    output logic [31:0] HWDATA_M,
    output logic        HREADY_M,
    output logic [3:0]  HMASTER_M,
    input  logic        HREADYOUT_M,
    input  logic        HRESP_M,
    input  logic [31:0] HRDATA_M
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_S0   = 2'd1,
        OWN_S1   = 2'd2
    } own_t;

    localparam logic RR = (ARB_MODE != 0);

    own_t        r_dp_own;
    logic        r_last;
    logic        r_pend0;
    logic        r_pend1;
    logic [31:0] r_paddr0;
    logic [31:0] r_paddr1;
    logic [1:0]  r_ptrans0;
    logic [1:0]  r_ptrans1;
    logic [2:0]  r_psize0;
    logic [2:0]  r_psize1;
    logic        r_pwrite0;
    logic        r_pwrite1;
    logic [31:0] r_haddr;
    logic [2:0]  r_hsize;
    logic        r_hwrite;
    logic        r_hmaster;

    logic        w_live0;
    logic        w_live1;
    logic        w_req0;
    logic        w_req1;
    logic        w_arb;
    logic        w_gnt0;
    logic        w_gnt1;
    logic        w_gnt;
    logic        w_err;
    logic [31:0] w_addr0;
    logic [31:0] w_addr1;
    logic [1:0]  w_trans0;
    logic [1:0]  w_trans1;
    logic [2:0]  w_size0;
    logic [2:0]  w_size1;
    logic        w_write0;
    logic        w_write1;
    logic [31:0] w_gaddr;
    logic [1:0]  w_gtrans;
    logic [2:0]  w_gsize;
    logic        w_gwrite;
    logic        w_mst;

    assign w_live0 = HSEL_S0 & HTRANS_S0[1] & HREADY_S0;
    assign w_live1 = HSEL_S1 & HTRANS_S1[1] & HREADY_S1;
    assign w_req0  = r_pend0 | w_live0;
    assign w_req1  = r_pend1 | w_live1;
    assign w_arb   = HREADYOUT_M & ~HRESET;
    assign w_err   = HRESP_M & ~HREADYOUT_M;
    assign w_gnt   = w_gnt0 | w_gnt1;

    assign w_addr0  = r_pend0 ? r_paddr0  : HADDR_S0;
    assign w_trans0 = r_pend0 ? r_ptrans0 : HTRANS_S0;
    assign w_size0  = r_pend0 ? r_psize0  : HSIZE_S0;
    assign w_write0 = r_pend0 ? r_pwrite0 : HWRITE_S0;
    assign w_addr1  = r_pend1 ? r_paddr1  : HADDR_S1;
    assign w_trans1 = r_pend1 ? r_ptrans1 : HTRANS_S1;
    assign w_size1  = r_pend1 ? r_psize1  : HSIZE_S1;
    assign w_write1 = r_pend1 ? r_pwrite1 : HWRITE_S1;

    assign w_gaddr  = w_gnt1 ? w_addr1  : w_addr0;
    assign w_gtrans = w_gnt1 ? w_trans1 : w_trans0;
    assign w_gsize  = w_gnt1 ? w_size1  : w_size0;
    assign w_gwrite = w_gnt1 ? w_write1 : w_write0;

    assign HREADY_M  = HREADYOUT_M;
    assign HRDATA_S0 = HRDATA_M;
    assign HRDATA_S1 = HRDATA_M;

    // Grant selection; a tie goes to S0 or to the port not granted last
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (w_arb) begin
            if (w_req0 && w_req1) begin
                if (!RR || r_last) begin
                    w_gnt0 = 1'b1;
                end else begin
                    w_gnt1 = 1'b1;
                end
            end else begin
                w_gnt0 = w_req0;
                w_gnt1 = w_req1;
            end
        end
    end

    // SRAM address phase; a change of owner restarts the burst as NONSEQ
    always_comb begin
        HSEL_M   = w_gnt;
        HTRANS_M = 2'b00;
        HADDR_M  = r_haddr;
        HSIZE_M  = r_hsize;
        HWRITE_M = r_hwrite;
        w_mst    = r_hmaster;
        if (w_gnt) begin
            HTRANS_M = (w_gnt1 != r_last) ? 2'b10 : w_gtrans;
            HADDR_M  = w_gaddr;
            HSIZE_M  = w_gsize;
            HWRITE_M = w_gwrite;
            w_mst    = w_gnt1;
        end
        HMASTER_M = HRESET ? 4'h0 : {3'b000, w_mst};
    end

    // Data phase routing to the owning port; a buffered port is stalled
    always_comb begin
        HWDATA_M     = 32'h0;
        HREADYOUT_S0 = 1'b1;
        HREADYOUT_S1 = 1'b1;
        HRESP_S0     = 1'b0;
        HRESP_S1     = 1'b0;
        if (!HRESET) begin
            case (r_dp_own)
                OWN_S0: begin
                    HWDATA_M     = HWDATA_S0;
                    HREADYOUT_S0 = HREADYOUT_M;
                    HRESP_S0     = HRESP_M;
                end
                OWN_S1: begin
                    HWDATA_M     = HWDATA_S1;
                    HREADYOUT_S1 = HREADYOUT_M;
                    HRESP_S1     = HRESP_M;
                end
                default: ;
            endcase
            if (r_pend0) HREADYOUT_S0 = 1'b0;
            if (r_pend1) HREADYOUT_S1 = 1'b0;
        end
    end

    // S0 buffer: capture a losing live request, drop on grant or error
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_pend0   <= 1'b0;
            r_paddr0  <= 32'h0;
            r_ptrans0 <= 2'b00;
            r_psize0  <= 3'b000;
            r_pwrite0 <= 1'b0;
        end else if (w_err && r_dp_own == OWN_S0) begin
            r_pend0 <= 1'b0;
        end else if (r_pend0) begin
            if (w_gnt0) r_pend0 <= 1'b0;
        end else if (w_live0 && !w_gnt0) begin
            r_pend0   <= 1'b1;
            r_paddr0  <= HADDR_S0;
            r_ptrans0 <= HTRANS_S0;
            r_psize0  <= HSIZE_S0;
            r_pwrite0 <= HWRITE_S0;
        end
    end

    // S1 buffer: capture a losing live request, drop on grant or error
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_pend1   <= 1'b0;
            r_paddr1  <= 32'h0;
            r_ptrans1 <= 2'b00;
            r_psize1  <= 3'b000;
            r_pwrite1 <= 1'b0;
        end else if (w_err && r_dp_own == OWN_S1) begin
            r_pend1 <= 1'b0;
        end else if (r_pend1) begin
            if (w_gnt1) r_pend1 <= 1'b0;
        end else if (w_live1 && !w_gnt1) begin
            r_pend1   <= 1'b1;
            r_paddr1  <= HADDR_S1;
            r_ptrans1 <= HTRANS_S1;
            r_psize1  <= HSIZE_S1;
            r_pwrite1 <= HWRITE_S1;
        end
    end

    // Data-phase owner, last-grant pointer and held address outputs
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_dp_own  <= OWN_NONE;
            r_last    <= 1'b1;
            r_haddr   <= 32'h0;
            r_hsize   <= 3'b000;
            r_hwrite  <= 1'b0;
            r_hmaster <= 1'b0;
        end else begin
            if (HREADYOUT_M) begin
                r_dp_own <= w_gnt0 ? OWN_S0 : (w_gnt1 ? OWN_S1 : OWN_NONE);
            end
            if (w_gnt) begin
                r_last    <= w_gnt1;
                r_haddr   <= w_gaddr;
                r_hsize   <= w_gsize;
                r_hwrite  <= w_gwrite;
                r_hmaster <= w_gnt1;
            end
        end
    end

endmodule

// File: tb/tb_ahb_ram_arbiter.sv
// tb_ahb_ram_arbiter: directed vectors against a fixed-priority (m=0)
// and a round-robin (m=1) instance driven by the same port stimulus.

module tb_ahb_ram_arbiter;

    logic        clk;
    logic        rst;
    logic        sel0, sel1, wr0, wr1, hr0, hr1;
    logic [31:0] addr0, addr1, wd0, wd1;
    logic [1:0]  trans0, trans1;
    logic [2:0]  size0, size1;
    logic        rdym, respm;
    logic [31:0] rdatam;

    logic        o_rdy0 [2];
    logic        o_rdy1 [2];
    logic        o_resp0 [2];
    logic        o_resp1 [2];
    logic [31:0] o_rd0 [2];
    logic [31:0] o_rd1 [2];
    logic        o_selm [2];
    logic [31:0] o_addrm [2];
    logic [1:0]  o_transm [2];
    logic [2:0]  o_sizem [2];
    logic        o_wrm [2];
    logic [31:0] o_wdm [2];
    logic        o_hrdym [2];
    logic [3:0]  o_mstm [2];

    int total = 0;
    int bad   = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        ahb_ram_arbiter #(.ARB_MODE(g)) u_dut (
            .HCLK         (clk),
            .HRESET       (rst),
            .HSEL_S0      (sel0),
            .HADDR_S0     (addr0),
            .HTRANS_S0    (trans0),
            .HSIZE_S0     (size0),
            .HWRITE_S0    (wr0),
            .HWDATA_S0    (wd0),
            .HREADY_S0    (hr0),
            .HREADYOUT_S0 (o_rdy0[g]),
            .HRESP_S0     (o_resp0[g]),
            .HRDATA_S0    (o_rd0[g]),
            .HSEL_S1      (sel1),
            .HADDR_S1     (addr1),
            .HTRANS_S1    (trans1),
            .HSIZE_S1     (size1),
            .HWRITE_S1    (wr1),
            .HWDATA_S1    (wd1),
            .HREADY_S1    (hr1),
            .HREADYOUT_S1 (o_rdy1[g]),
            .HRESP_S1     (o_resp1[g]),
            .HRDATA_S1    (o_rd1[g]),
            .HSEL_M       (o_selm[g]),
            .HADDR_M      (o_addrm[g]),
            .HTRANS_M     (o_transm[g]),
            .HSIZE_M      (o_sizem[g]),
            .HWRITE_M     (o_wrm[g]),
            .HWDATA_M     (o_wdm[g]),
            .HREADY_M     (o_hrdym[g]),
            .HMASTER_M    (o_mstm[g]),
            .HREADYOUT_M  (rdym),
            .HRESP_M      (respm),
            .HRDATA_M     (rdatam)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        sel0 = 0; addr0 = 0; trans0 = 0; size0 = 3'b010;
        wr0 = 0; wd0 = 0; hr0 = 1;
        sel1 = 0; addr1 = 0; trans1 = 0; size1 = 3'b010;
        wr1 = 0; wd1 = 0; hr1 = 1;
    endtask

    task automatic drv0(input logic [31:0] a, input logic [1:0] t,
                        input logic w, input logic r);
        sel0 = 1; addr0 = a; trans0 = t; wr0 = w; hr0 = r;
    endtask

    task automatic drv1(input logic [31:0] a, input logic [1:0] t,
                        input logic w, input logic r);
        sel1 = 1; addr1 = a; trans1 = t; wr1 = w; hr1 = r;
    endtask

    task automatic do_reset();
        rst = 1;
        idle_all();
        rdym = 1; respm = 0; rdatam = 0;
        next();
        next();
        rst = 0;
    endtask

    initial begin
        rst = 1;
        idle_all();
        rdym = 1; respm = 0; rdatam = 0;
        #1;
        do_reset();

        // reset state
        settle();
        for (int m = 0; m < 2; m++) begin
            check($sformatf("rst rdy0 m%0d", m), o_rdy0[m], 1);
            check($sformatf("rst rdy1 m%0d", m), o_rdy1[m], 1);
            check($sformatf("rst resp0 m%0d", m), o_resp0[m], 0);
            check($sformatf("rst resp1 m%0d", m), o_resp1[m], 0);
            check($sformatf("rst selm m%0d", m), o_selm[m], 0);
            check($sformatf("rst transm m%0d", m), o_transm[m], 0);
            check($sformatf("rst wdm m%0d", m), o_wdm[m], 0);
            check($sformatf("rst mst m%0d", m), o_mstm[m], 0);
        end
        next();

        // S0 alone, zero-wait read
        drv0(32'h10, 2'b10, 0, 1);
        settle();
        for (int m = 0; m < 2; m++) begin
            check($sformatf("s0rd sel m%0d", m), o_selm[m], 1);
            check($sformatf("s0rd addr m%0d", m), o_addrm[m], 32'h10);
            check($sformatf("s0rd trans m%0d", m), o_transm[m], 2'b10);
            check($sformatf("s0rd mst m%0d", m), o_mstm[m], 0);
            check($sformatf("s0rd rdy0 m%0d", m), o_rdy0[m], 1);
            check($sformatf("s0rd hrdym m%0d", m), o_hrdym[m], 1);
        end
        next();
        idle_all();
        rdatam = 32'hDEADBEEF;
        settle();
        for (int m = 0; m < 2; m++) begin
            check($sformatf("s0rd data m%0d", m), o_rd0[m], 32'hDEADBEEF);
            check($sformatf("s0rd fan m%0d", m), o_rd1[m], 32'hDEADBEEF);
            check($sformatf("s0rd rdy0b m%0d", m), o_rdy0[m], 1);
            check($sformatf("s0rd idle m%0d", m), o_selm[m], 0);
        end
        next();

        // same-cycle contention, S0 wins, S1 replayed next slot
        do_reset();
        drv0(32'h20, 2'b10, 0, 1);
        drv1(32'h30, 2'b10, 0, 1);
        settle();
        for (int m = 0; m < 2; m++) begin
            check($sformatf("tie c0 addr m%0d", m), o_addrm[m], 32'h20);
            check($sformatf("tie c0 mst m%0d", m), o_mstm[m], 0);
            check($sformatf("tie c0 rdy1 m%0d", m), o_rdy1[m], 1);
        end
        next();
        idle_all();
        hr1 = 0;
        settle();
        for (int m = 0; m < 2; m++) begin
            check($sformatf("tie c1 sel m%0d", m), o_selm[m], 1);
            check($sformatf("tie c1 addr m%0d", m), o_addrm[m], 32'h30);
            check($sformatf("tie c1 mst m%0d", m), o_mstm[m], 1);
            check($sformatf("tie c1 trans m%0d", m), o_transm[m], 2'b10);
            check($sformatf("tie c1 rdy1 m%0d", m), o_rdy1[m], 0);
        end
        next();
        rdym = 0;
        settle();
        for (int m = 0; m < 2; m++) begin
            check($sformatf("tie c2 rdy1 m%0d", m), o_rdy1[m], 0);
            check($sformatf("tie c2 sel m%0d", m), o_selm[m], 0);
        end
        next();
        rdym = 1; hr1 = 1; rdatam = 32'h3333_0000;
        settle();
        for (int m = 0; m < 2; m++) begin
            check($sformatf("tie c3 rdy1 m%0d", m), o_rdy1[m], 1);
            check($sformatf("tie c3 rd1 m%0d", m), o_rd1[m], 32'h3333_0000);
        end
        next();

        // S1 SEQ burst interrupted by S0
        do_reset();
        drv1(32'h40, 2'b10, 0, 1);
        settle();
        check("burst c0 mst", o_mstm[0], 1);
        next();
        drv1(32'h44, 2'b11, 0, 1);
        drv0(32'h50, 2'b10, 0, 1);
        settle();
        for (int m = 0; m < 2; m++) begin
            check($sformatf("burst c1 addr m%0d", m), o_addrm[m], 32'h50);
            check($sformatf("burst c1 mst m%0d", m), o_mstm[m], 0);
        end
        next();
        idle_all();
        drv1(32'h48, 2'b11, 0, 0);
        settle();
        for (int m = 0; m < 2; m++) begin
            check($sformatf("burst c2 addr m%0d", m), o_addrm[m], 32'h44);
            check($sformatf("burst c2 trans m%0d", m), o_transm[m], 2'b10);
            check($sformatf("burst c2 mst m%0d", m), o_mstm[m], 1);
        end
        next();
        hr1 = 1;
        settle();
        for (int m = 0; m < 2; m++) begin
            check($sformatf("burst c3 addr m%0d", m), o_addrm[m], 32'h48);
            check($sformatf("burst c3 trans m%0d", m), o_transm[m], 2'b11);
        end
        next();

        // round-robin, both ports writing back to back
        do_reset();
        for (int k = 0; k < 8; k++) begin
            int j;
            logic [31:0] ea, ed;
            logic [3:0]  em;
            sel0 = 1; sel1 = 1; trans0 = 2'b10; trans1 = 2'b10;
            wr0 = 1; wr1 = 1;
            if (k == 0) begin
                addr0 = 32'h100; hr0 = 1; wd0 = 0;
                addr1 = 32'h200; hr1 = 1; wd1 = 0;
            end else if (k % 2 == 1) begin
                j = (k + 1) / 2;
                addr0 = 32'h100 + 4 * j; hr0 = 1; wd0 = 32'hA000_0000 + j - 1;
                addr1 = 32'h200 + 4 * j; hr1 = 0; wd1 = 32'hB000_0000 + j - 1;
            end else begin
                j = k / 2;
                addr0 = 32'h100 + 4 * (j + 1); hr0 = 0; wd0 = 32'hA000_0000 + j;
                addr1 = 32'h200 + 4 * j; hr1 = 1; wd1 = 32'hB000_0000 + j - 1;
            end
            if (k % 2 == 0) begin
                ea = 32'h100 + 4 * (k / 2);
                em = 4'h0;
                ed = (k == 0) ? 32'h0 : 32'hB000_0000 + k / 2 - 1;
            end else begin
                ea = 32'h200 + 4 * ((k - 1) / 2);
                em = 4'h1;
                ed = 32'hA000_0000 + (k - 1) / 2;
            end
            settle();
            check($sformatf("rr k%0d addr", k), o_addrm[1], ea);
            check($sformatf("rr k%0d mst", k), o_mstm[1], em);
            check($sformatf("rr k%0d wdata", k), o_wdm[1], ed);
            next();
        end

        // SRAM error to S1 while a second S1 request is buffered
        do_reset();
        drv1(32'h60, 2'b10, 1, 1);
        settle();
        check("err c0 mst", o_mstm[0], 1);
        next();
        rdym = 0;
        drv1(32'h64, 2'b10, 1, 1);
        settle();
        for (int m = 0; m < 2; m++)
            check($sformatf("err c1 rdy1 m%0d", m), o_rdy1[m], 0);
        next();
        respm = 1;
        settle();
        for (int m = 0; m < 2; m++) begin
            check($sformatf("err c2 resp1 m%0d", m), o_resp1[m], 1);
            check($sformatf("err c2 rdy1 m%0d", m), o_rdy1[m], 0);
            check($sformatf("err c2 resp0 m%0d", m), o_resp0[m], 0);
        end
        next();
        rdym = 1;
        idle_all();
        settle();
        for (int m = 0; m < 2; m++) begin
            check($sformatf("err c3 resp1 m%0d", m), o_resp1[m], 1);
            check($sformatf("err c3 rdy1 m%0d", m), o_rdy1[m], 1);
            check($sformatf("err c3 sel m%0d", m), o_selm[m], 0);
        end
        next();
        respm = 0;
        settle();
        for (int m = 0; m < 2; m++) begin
            check($sformatf("err c4 resp1 m%0d", m), o_resp1[m], 0);
            check($sformatf("err c4 sel m%0d", m), o_selm[m], 0);
            check($sformatf("err c4 trans m%0d", m), o_transm[m], 0);
        end
        next();

        // reset with S0 buffered and SRAM in a wait state
        do_reset();
        drv1(32'h70, 2'b10, 1, 1);
        next();
        idle_all();
        wd1 = 32'h1234;
        rdym = 0;
        drv0(32'h80, 2'b10, 0, 1);
        settle();
        check("rstm c1 rdy0", o_rdy0[0], 1);
        next();
        hr0 = 0;
        settle();
        check("rstm c2 rdy0", o_rdy0[0], 0);
        next();
        rst = 1;
        settle();
        for (int m = 0; m < 2; m++) begin
            check($sformatf("rstm in rdy0 m%0d", m), o_rdy0[m], 1);
            check($sformatf("rstm in wdm m%0d", m), o_wdm[m], 0);
            check($sformatf("rstm in mst m%0d", m), o_mstm[m], 0);
            check($sformatf("rstm in sel m%0d", m), o_selm[m], 0);
        end
        next();
        rst = 0;
        rdym = 1;
        idle_all();
        wd1 = 32'h1234;
        settle();
        for (int m = 0; m < 2; m++) begin
            check($sformatf("rstm rdy0 m%0d", m), o_rdy0[m], 1);
            check($sformatf("rstm rdy1 m%0d", m), o_rdy1[m], 1);
            check($sformatf("rstm resp0 m%0d", m), o_resp0[m], 0);
            check($sformatf("rstm resp1 m%0d", m), o_resp1[m], 0);
            check($sformatf("rstm sel m%0d", m), o_selm[m], 0);
            check($sformatf("rstm trans m%0d", m), o_transm[m], 0);
            check($sformatf("rstm wdm m%0d", m), o_wdm[m], 0);
            check($sformatf("rstm mst m%0d", m), o_mstm[m], 0);
        end
        next();
        settle();
        for (int m = 0; m < 2; m++)
            check($sformatf("rstm after sel m%0d", m), o_selm[m], 0);
        next();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ahb_ram_arbiter.md
AHB_RAM_ARBITER -- requirements
Module: ahb_ram_arbiter

Interface
REQ-001 Parameter: ARB_MODE, default 0, selects arbitration: 0 = fixed priority (S0 over S1), 1 = round-robin.
REQ-002 HCLK  input  1  sole clock; all state updates on rising edge.
REQ-003 HRESET  input  1  reset, synchronous, active-high.
REQ-004 HSEL_S0 / HSEL_S1  input  1  slave-port select, processor port (S0) and DMA port (S1).
REQ-005 HADDR_S0 / HADDR_S1  input  32  address.
REQ-006 HTRANS_S0 / HTRANS_S1  input  2  transfer type.
REQ-007 HSIZE_S0 / HSIZE_S1  input  3  transfer size.
REQ-008 HWRITE_S0 / HWRITE_S1  input  1  write control.
REQ-009 HWDATA_S0 / HWDATA_S1  input  32  write data.
REQ-010 HREADY_S0 / HREADY_S1  input  1  port-side transfer-done.
REQ-011 HREADYOUT_S0 / HREADYOUT_S1  output  1  port ready.
REQ-012 HRESP_S0 / HRESP_S1  output  1  port response.
REQ-013 HRDATA_S0 / HRDATA_S1  output  32  read data.
REQ-014 HSEL_M, HADDR_M[31:0], HTRANS_M[1:0], HSIZE_M[2:0], HWRITE_M, HWDATA_M[31:0]  output  address/data phase to the shared SRAM.
REQ-015 HREADY_M  output  1  HREADY to the SRAM, equal to HREADYOUT_M.
REQ-016 HMASTER_M  output  4  {3'b000, address-phase owner}, for SRAM exclusive monitor.
REQ-017 HREADYOUT_M, HRESP_M  input  1  SRAM ready/response.
REQ-018 HRDATA_M  input  32  SRAM read data.

Function
REQ-019 Port request = HSEL_Sx & HTRANS_Sx[1] & HREADY_Sx (live), or pend_x = 1 (buffered).
REQ-020 Live request not granted in the same cycle SHALL be captured into a pending register (addr, trans, size, write) with pend_x <= 1.
REQ-021 Arbitration occurs only in cycles with HREADYOUT_M = 1; a pending request is presented before any new live request of the same port.
REQ-022 ARB_MODE 0: S0 wins all ties; ARB_MODE 1: on tie, the port not granted most recently wins; the last-grant pointer updates on every grant.
REQ-023 Granted live request SHALL pass combinationally to the M outputs; granted pending request is driven from the register and pend_x clears at that edge.
REQ-024 No grant: HSEL_M = 0, HTRANS_M = 2'b00 (IDLE); other M address outputs hold last value.
REQ-025 HTRANS_M = NONSEQ (2'b10) when the granted port differs from the previous granted port, even if the port issued SEQ.
REQ-026 Data-phase owner dp_own (NONE/S0/S1) <= granted port at each edge with HREADYOUT_M = 1; NONE if no grant.
REQ-027 HWDATA_M = HWDATA of dp_own (32'h0 when NONE); HRDATA_M fanned out unmodified to both ports.
REQ-028 HREADYOUT_Sx: 0 while pend_x = 1; else HREADYOUT_M when dp_own = x; else 1.
REQ-029 HRESP_Sx = HRESP_M when dp_own = x, else 0.
REQ-030 ERROR (HRESP_M = 1, HREADYOUT_M = 0) to port x SHALL clear pend_x in that cycle; the port re-presents at the end of error cycle 2 and is sampled fresh.
REQ-031 Simultaneous live S0 request and pending S1: pending S1 arbitrated as a request equal to live S0 per REQ-022; loser buffered.
REQ-032 Maximum one pending transfer per port; a port with pend_x = 1 is stalled, so no second capture occurs.
REQ-033 Zero added latency for an uncontended transfer; a contended transfer waits exactly one SRAM address slot per winning transfer.

Reset
REQ-034 HRESET = 1 at a rising edge: pend_0 = pend_1 = 0, dp_own = NONE, last-grant = S1 (so S0 wins first RR tie), pending registers = 0.
REQ-035 During and after reset: HREADYOUT_Sx = 1, HRESP_Sx = 0, HSEL_M = 0, HTRANS_M = IDLE, HWDATA_M = 0, HMASTER_M = 0.
REQ-036 Reset mid-transfer SHALL discard pending and in-flight state without issuing further M transfers.

Verification
REQ-037 S0 alone, NONSEQ read 0x0000_0010, SRAM zero-wait -> HSEL_M same cycle, HREADYOUT_S0 = 1 throughout, HRDATA_S0 = SRAM data next cycle.
REQ-038 ARB_MODE 0, S0 and S1 NONSEQ same cycle -> S0 granted, S1 pended, HREADYOUT_S1 = 0 for 2 cycles, S1 address on M next cycle, HMASTER_M = 4'h1 then.
REQ-039 ARB_MODE 1, both ports issue back-to-back writes for 8 cycles -> grants alternate S0,S1,S0,...; each HWDATA_M matches dp_own port's data.
REQ-040 S1 SEQ burst interrupted by S0 grant -> resumed S1 beat appears with HTRANS_M = 2'b10.
REQ-041 SRAM ERROR to S1 while S1 pending -> HRESP_S1 = 1 for 2 cycles, pend_1 cleared, S1 IDLE afterwards produces no M transfer.
REQ-042 HRESET asserted with pend_0 = 1 and SRAM wait-state -> next cycle all REQ-035 values, no M transfer after reset release until new request.
